// File: rtl/convo_core_kxk.sv
// convo_core_kxk: FP32 KSIZE x KSIZE window dot-product through a registered adder tree,
// then per-pixel accumulation over NUM_CH channels plus bias. Optional ReLU: CONVO_KXK_RELU_EN.

module FP_Mul (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        RMode,  // 0: round-nearest-even, 1: truncate
  output logic [31:0] Result
);
  logic               s;
  logic [7:0]         ea, eb;
  logic [47:0]        prod;
  logic [22:0]        frac;
  logic               g, st, inc;
  logic [23:0]        rnd;
  logic signed [10:0] e;

  // Denormal operands are flushed to zero; results below the normal range flush to zero.
  always_comb begin
    s    = A[31] ^ B[31];
    ea   = A[30:23];
    eb   = B[30:23];
    prod = {24'b0, 1'b1, A[22:0]} * {24'b0, 1'b1, B[22:0]};
    e    = $signed({3'b0, ea}) + $signed({3'b0, eb}) - 11'sd127;
    if (prod[47]) begin
      frac = prod[46:24];
      g    = prod[23];
      st   = |prod[22:0];
      e    = e + 11'sd1;
    end else begin
      frac = prod[45:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    inc = !RMode && g && (st || frac[0]);
    rnd = {1'b0, frac} + {23'b0, inc};
    if (rnd[23]) e = e + 11'sd1;
    Result = {s, e[7:0], rnd[22:0]};
    if (e >= 11'sd255)     Result = {s, 8'hFF, 23'b0};
    else if (e <= 11'sd0)  Result = {s, 31'b0};
    if ((ea == 8'hFF && A[22:0] != 0) || (eb == 8'hFF && B[22:0] != 0) ||
        (ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00))
      Result = 32'h7FC0_0000;
    else if (ea == 8'hFF || eb == 8'hFF)
      Result = {s, 8'hFF, 23'b0};
    else if (ea == 8'h00 || eb == 8'h00)
      Result = {s, 31'b0};
  end
endmodule

module FP_Adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Mode,   // 0: A+B, 1: A-B
  input  logic        RMode,  // 0: round-nearest-even, 1: truncate
  output logic [31:0] Result
);
  logic               bs, swap, sx, sy, sub, inc;
  logic [31:0]        x, y;
  logic [7:0]         ex, ey, d;
  logic [23:0]        mx, my;
  logic [4:0]         dsh, lz;
  logic [50:0]        wide;
  logic [26:0]        al, n;
  logic [27:0]        s;
  logic [23:0]        rnd;
  logic signed [10:0] e;

  function automatic logic [4:0] lzc(input logic [26:0] v);
    lzc = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc = 5'(26 - i);
  endfunction

  // x is the larger-magnitude operand; y is aligned into 24 mantissa + guard/round/sticky bits.
  always_comb begin
    bs   = B[31] ^ Mode;
    swap = B[30:0] > A[30:0];
    x    = swap ? B : A;
    y    = swap ? A : B;
    sx   = swap ? bs : A[31];
    sy   = swap ? A[31] : bs;
    ex   = x[30:23];
    ey   = y[30:23];
    mx   = (ex == 8'h00) ? 24'd0 : {1'b1, x[22:0]};
    my   = (ey == 8'h00) ? 24'd0 : {1'b1, y[22:0]};
    d    = ex - ey;
    dsh  = (d > 8'd31) ? 5'd31 : d[4:0];
    wide = {my, 27'b0} >> dsh;
    al   = {wide[50:25], |wide[24:0]};
    sub  = sx ^ sy;
    s    = sub ? ({1'b0, mx, 3'b0} - {1'b0, al}) : ({1'b0, mx, 3'b0} + {1'b0, al});
    e    = $signed({3'b0, ex});
    lz   = lzc(s[26:0]);
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = e + 11'sd1;
    end else begin
      n = s[26:0] << lz;
      e = e - $signed({6'b0, lz});
    end
    inc = !RMode && n[2] && (n[1] || n[0] || n[3]);
    rnd = {1'b0, n[25:3]} + {23'b0, inc};
    if (rnd[23]) e = e + 11'sd1;
    Result = {sx, e[7:0], rnd[22:0]};
    if (e >= 11'sd255)     Result = {sx, 8'hFF, 23'b0};
    else if (e <= 11'sd0)  Result = {sx, 31'b0};
    if (!n[26])            Result = {sx & sy, 31'b0};
    if (ex == 8'hFF) begin
      if (x[22:0] != 0 || (ey == 8'hFF && sub)) Result = 32'h7FC0_0000;
      else                                      Result = {sx, 8'hFF, 23'b0};
    end
  end
endmodule

module convo_core_kxk #(
  parameter  int KSIZE  = 3,
  parameter  int NUM_CH = 1,
  localparam int CH_W   = $clog2(NUM_CH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KSIZE*KSIZE*32-1:0] Data_In,
  input  logic [KSIZE*KSIZE*32-1:0] Kernel,
  input  logic [31:0]               Bias,
  input  logic                      Valid_In,
  input  logic                      Stall,
  input  logic                      Clear,
  output logic [31:0]               Data_Out,
  output logic                      Valid_Out,
  output logic [CH_W-1:0]           Ch_Idx
);
  localparam int NPROD = KSIZE * KSIZE;
  localparam int LVLS  = $clog2(NPROD);   // tree result sits LVLS+1 registers after the input
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  function automatic int lvl_cnt(input int l);
    int c = NPROD;
    for (int i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef CONVO_KXK_RELU_EN
    return v[31] ? 32'h0000_0000 : v;
`else
    return v;
`endif
  endfunction

  logic en;
  assign en = !Stall;

  // Level 0 registers the products; each further level registers one pairwise add pass.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int CNT = lvl_cnt(l);
    logic [31:0] d_p [CNT];
    logic [31:0] nxt [CNT];
    logic        vld_p;
    logic        vld_in;

    if (l == 0) begin : g_mul
      assign vld_in = Valid_In;
      for (genvar j = 0; j < CNT; j++) begin : g_j
        FP_Mul u_mul (
          .A(Data_In[j*32 +: 32]), .B(Kernel[j*32 +: 32]), .RMode(1'b0), .Result(nxt[j])
        );
      end
    end else begin : g_add
      localparam int PCNT = lvl_cnt(l - 1);
      assign vld_in = g_lvl[l-1].vld_p;
      for (genvar j = 0; j < CNT; j++) begin : g_j
        if (2*j + 1 < PCNT) begin : g_pair
          FP_Adder u_add (
            .A(g_lvl[l-1].d_p[2*j]), .B(g_lvl[l-1].d_p[2*j+1]),
            .Mode(1'b0), .RMode(1'b0), .Result(nxt[j])
          );
        end else begin : g_pass
          assign nxt[j] = g_lvl[l-1].d_p[2*j];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_p <= 1'b0;
        for (int j = 0; j < CNT; j++) d_p[j] <= '0;
      end else if (Clear) begin
        vld_p <= 1'b0;
      end else if (en) begin
        vld_p <= vld_in;
        d_p   <= nxt;
      end
    end
  end

  // Accumulator stage: channel 0 starts from Bias, the last channel writes the pixel out.
  logic [31:0]     tree_res, addend, sum, acc_p;
  logic            tree_vld, out_vld_p;
  logic [CH_W-1:0] ch_cnt;

  assign tree_res = g_lvl[LVLS].d_p[0];
  assign tree_vld = g_lvl[LVLS].vld_p;
  assign addend   = (ch_cnt == '0) ? Bias : acc_p;

  FP_Adder u_acc (.A(addend), .B(tree_res), .Mode(1'b0), .RMode(1'b0), .Result(sum));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p     <= '0;
      ch_cnt    <= '0;
      Data_Out  <= '0;
      out_vld_p <= 1'b0;
    end else if (Clear) begin
      acc_p     <= '0;
      ch_cnt    <= '0;
      out_vld_p <= 1'b0;
    end else if (en) begin
      out_vld_p <= 1'b0;
      if (tree_vld) begin
        if (ch_cnt == LAST_CH) begin
          Data_Out  <= relu(sum);
          out_vld_p <= 1'b1;
          ch_cnt    <= '0;
        end else begin
          acc_p  <= sum;
          ch_cnt <= ch_cnt + CH_W'(1);
        end
      end
    end
  end

  // A pending pulse is held in out_vld_p while stalled and shows on the first free cycle.
  assign Valid_Out = out_vld_p & !Stall;
  assign Ch_Idx    = ch_cnt;
endmodule

// File: tb/tb_convo_core_kxk.sv
// Directed bench for convo_core_kxk: one NUM_CH=1 and one NUM_CH=2 instance on shared inputs.
module tb_convo_core_kxk;
  localparam int NP = 9;
  localparam logic [31:0] ONE = 32'h3F80_0000;
  localparam logic [31:0] HALF = 32'h3F00_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP*32-1:0] data_in = '0, kernel = '0;
  logic [31:0] bias = '0;
  logic valid_in = 1'b0, stall = 1'b0, clear = 1'b0;
  logic [31:0] d1, d2;
  logic v1, v2;
  logic [0:0] ci1;
  logic [1:0] ci2;

  convo_core_kxk #(.KSIZE(3), .NUM_CH(1)) u1 (
    .clk(clk), .rst(rst_n), .Data_In(data_in), .Kernel(kernel), .Bias(bias),
    .Valid_In(valid_in), .Stall(stall), .Clear(clear),
    .Data_Out(d1), .Valid_Out(v1), .Ch_Idx(ci1)
  );
  convo_core_kxk #(.KSIZE(3), .NUM_CH(2)) u2 (
    .clk(clk), .rst(rst_n), .Data_In(data_in), .Kernel(kernel), .Bias(bias),
    .Valid_In(valid_in), .Stall(stall), .Clear(clear),
    .Data_Out(d2), .Valid_Out(v2), .Ch_Idx(ci2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] v; } ev_t;
  ev_t q1[$], q2[$];
  always @(negedge clk) begin
    if (v1) q1.push_back(ev_t'{cyc, d1});
    if (v2) q2.push_back(ev_t'{cyc, d2});
  end

  int total = 0, bad = 0;

  function automatic logic [31:0] rexp(input logic [31:0] v);
`ifdef CONVO_KXK_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic pop(input bit sel, input string nm, input int ec, input logic [31:0] ev);
    ev_t e;
    if ((sel ? q2.size() : q1.size()) == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no Valid_Out pulse, want cycle %0d data %h", nm, ec, rexp(ev));
    end else begin
      if (sel) e = q2.pop_front();
      else     e = q1.pop_front();
      chk({nm, " cycle"}, e.c, ec);
      chk({nm, " data"}, e.v, rexp(ev));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic set_win(input logic [31:0] d0, input logic [31:0] dr, input logic [31:0] kr);
    data_in = {{(NP-1){dr}}, d0};
    kernel  = {NP{kr}};
  endtask

  task automatic flush();
    q1.delete();
    q2.delete();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    flush();
  endtask

  typedef struct { logic [31:0] d0, dr, kr, b, exp; } vec_t;
  vec_t tbl[14];
  logic [31:0] kv [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                          32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

  initial begin
    int c0, c1;
    tbl[0]  = '{ONE, ONE, ONE, 32'h0, 32'h4110_0000};
    for (int k = 0; k < 8; k++) tbl[1+k] = '{kv[k], 32'h0, ONE, 32'h0, kv[k]};
    tbl[9]  = '{ONE, ONE, 32'hBF80_0000, 32'h0, 32'hC110_0000};
    tbl[10] = '{32'h4000_0000, 32'h4000_0000, HALF, ONE, 32'h4120_0000};
    tbl[11] = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h3FC0_0000, 32'h0, 32'h41A2_0000};
    tbl[12] = '{ONE, ONE, ONE, 32'hC110_0000, 32'h0000_0000};
    tbl[13] = '{32'h0, 32'h0, ONE, HALF, HALF};

    repeat (3) step();
    @(negedge clk);
    chk("reset vout1", {31'b0, v1}, 0);
    chk("reset vout2", {31'b0, v2}, 0);
    chk("reset dout1", d1, 0);
    chk("reset dout2", d2, 0);
    chk("reset chidx2", {30'b0, ci2}, 0);
    step();
    rst_n = 1'b1;
    step();
    flush();

    // Single-window vectors, one pulse each, checked for value and 6-cycle latency.
    for (int i = 0; i < 14; i++) begin
      set_win(tbl[i].d0, tbl[i].dr, tbl[i].kr);
      bias = tbl[i].b;
      c0 = cyc;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      repeat (8) step();
      pop(0, $sformatf("vec%0d", i), c0 + 6, tbl[i].exp);
      chk($sformatf("vec%0d extra", i), q1.size(), 0);
      do_clear();
    end

    // Eight back-to-back windows -> eight consecutive pulses.
    bias = 32'h0;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      set_win(kv[k], 32'h0, ONE);
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    repeat (10) step();
    for (int k = 0; k < 8; k++) pop(0, $sformatf("stream%0d", k), c0 + 6 + k, kv[k]);
    chk("stream extra", q1.size(), 0);
    do_clear();

    // Two channels with bias 0.5 -> 18.5, Ch_Idx 0,1,0.
    set_win(ONE, ONE, ONE);
    bias = HALF;
    c0 = cyc;
    valid_in = 1'b1;
    step();
    step();
    valid_in = 1'b0;
    to_cyc(c0 + 5);
    @(negedge clk);
    chk("chidx t5", {30'b0, ci2}, 0);
    step();
    @(negedge clk);
    chk("chidx t6", {30'b0, ci2}, 1);
    step();
    @(negedge clk);
    chk("chidx t7", {30'b0, ci2}, 0);
    repeat (4) step();
    pop(1, "ch2 pixel", c0 + 7, 32'h4194_0000);
    chk("ch2 extra", q2.size(), 0);
    do_clear();

    // Two pixels back-to-back on the NUM_CH=2 instance.
    c0 = cyc;
    valid_in = 1'b1;
    repeat (4) step();
    valid_in = 1'b0;
    repeat (10) step();
    pop(1, "b2b pix0", c0 + 7, 32'h4194_0000);
    pop(1, "b2b pix1", c0 + 9, 32'h4194_0000);
    chk("b2b extra", q2.size(), 0);
    do_clear();

    // Stall 3 cycles mid-tree; a Valid_In during the stall is ignored.
    bias = 32'h0;
    c0 = cyc;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    stall = 1'b1;
    step();
    set_win(kv[7], ONE, ONE);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    set_win(ONE, ONE, ONE);
    step();
    stall = 1'b0;
    repeat (10) step();
    pop(0, "stall mid", c0 + 9, 32'h4110_0000);
    chk("stall extra", q1.size(), 0);
    do_clear();

    // Stall in the cycle the pulse would show: it moves one cycle later.
    c0 = cyc;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    to_cyc(c0 + 6);
    stall = 1'b1;
    step();
    stall = 1'b0;
    repeat (4) step();
    pop(0, "stall out", c0 + 7, 32'h4110_0000);
    chk("stall out extra", q1.size(), 0);
    do_clear();

    // Clear while in flight: nothing emerges and Data_Out holds.
    set_win(kv[7], ONE, ONE);
    c0 = cyc;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    to_cyc(c0 + 2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (10) step();
    chk("clear flight q1", q1.size(), 0);
    chk("clear flight q2", q2.size(), 0);
    chk("clear hold dout", d1, rexp(32'h4110_0000));

    // One channel accumulated, then Clear: the next pair must not mix with it.
    bias = HALF;
    c0 = cyc;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    to_cyc(c0 + 8);
    @(negedge clk);
    chk("pre-clear chidx", {30'b0, ci2}, 1);
    do_clear();
    @(negedge clk);
    chk("post-clear chidx", {30'b0, ci2}, 0);
    set_win(ONE, ONE, ONE);
    step();
    c1 = cyc;
    valid_in = 1'b1;
    step();
    step();
    valid_in = 1'b0;
    repeat (10) step();
    pop(1, "after clear", c1 + 7, 32'h4194_0000);
    chk("after clear extra", q2.size(), 0);
    do_clear();

    // Reset mid-tree discards in-flight work and zeroes outputs.
    bias = 32'h0;
    c0 = cyc;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    to_cyc(c0 + 2);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("rst mid q1", q1.size(), 0);
    chk("rst mid q2", q2.size(), 0);
    chk("rst mid dout1", d1, 0);
    chk("rst mid dout2", d2, 0);
    chk("rst mid chidx2", {30'b0, ci2}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/convo_core_kxk.md
Name: convo_core_kxk

Overview:
- Parametrised FP32 convolution core: one KSIZE x KSIZE window dot-product per cycle, pipelined binary adder tree, then per-output-pixel accumulation over NUM_CH input channels plus bias.
- Sits between the line-buffer/window generator and the activation/output writer in the convolution datapath.
- Instantiates the codebase FP_Mul and FP_Adder units as combinational FP32 operators (Mode=0 add, RMode=0 round-nearest-even). All pipeline state lives in this block.

Parameters:
- KSIZE, 3, kernel side; legal 1..7; KSIZE*KSIZE products per window.
- NUM_CH, 1, input channels accumulated per output pixel; legal 1..1024.
- TREE_LAT, derived = 1 + ceil(log2(KSIZE*KSIZE)), register stages from input to tree result (3->5, 5->6, 1->1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- Data_In  input  KSIZE*KSIZE*32  window; element i at [i*32 +: 32], row-major.
- Kernel  input  KSIZE*KSIZE*32  weights; same packing as Data_In.
- Bias  input  32  FP32 bias, sampled when channel 0's tree result reaches the accumulator.
- Valid_In  input  1  window/kernel pair valid this cycle.
- Stall  input  1  freeze whole pipeline.
- Clear  input  1  synchronous flush of in-flight data and channel count.
- Data_Out  output  32  FP32 result for one output pixel.
- Valid_Out  output  1  one-cycle pulse, Data_Out valid.
- Ch_Idx  output  ceil(log2(NUM_CH))+1  channel index expected next at the accumulator.

Behaviour:
- Reset (rst=0, async): all stage data registers, valid shift bits, accumulator, Data_Out = 0; Valid_Out = 0; Ch_Idx = 0.
- Stage 0: KSIZE*KSIZE FP_Mul products registered together with valid bit v[0] = Valid_In.
- Tree levels: pairwise FP_Adder per level, each level registered.
  - An odd leftover element is passed through unchanged into the next level's register.
  - Each level carries its own valid bit, so bubbles are allowed and no global counter is used.
- Tree result is valid TREE_LAT cycles after Valid_In is accepted.
- Accumulator stage, on tree-valid:
  - sum = (ch_cnt==0 ? Bias : acc) + tree, via one FP_Adder.
  - If ch_cnt < NUM_CH-1: acc <= sum; ch_cnt++.
  - If ch_cnt == NUM_CH-1: Data_Out <= sum; Valid_Out <= 1; ch_cnt <= 0. acc is don't-care.
- End-to-end latency: last channel's Valid_In at cycle n -> Valid_Out at n+TREE_LAT+1 (KSIZE=3: n+6).
- Throughput: one window per cycle. A new pixel's channel 0 may follow the previous pixel's last channel back-to-back with no gap.
- Valid_Out is deasserted in every cycle not listed above. Data_Out holds its last value.
- Stall=1:
  - No register updates.
  - Valid_In is ignored, not captured.
  - Valid_Out is forced to 0 during the stall and re-emitted on the first unstalled cycle if it was pending.
- Clear=1: all valid bits, ch_cnt and acc are cleared next edge; Data_Out is held. Clear has priority over Stall and Valid_In.
- Reset mid-operation: all in-flight results are discarded; no Valid_Out until fresh inputs traverse the full latency.
- Special values: NaN/Inf/denormal handling is inherited from FP_Mul and FP_Adder, with no extra checks here.
- Ch_Idx = ch_cnt.

Optional Feature:
- Macro CONVO_KXK_RELU_EN.
- Defined: at the final write, if sum[31]==1 (negative, including -0), Data_Out <= 32'h0000_0000; otherwise Data_Out <= sum. No added latency.
- Undefined: Data_Out <= sum unmodified.

Test Plan:
- KSIZE=3, NUM_CH=1, all Data/Kernel = 0x3F800000 (1.0), Bias=0: single Valid_In at cycle 10 -> Valid_Out at cycle 16, Data_Out=0x41100000 (9.0).
- Same config, Valid_In held for 8 cycles with Data_In element 0 = k·1.0 for k=1..8, others 0, Bias=0: 8 consecutive Valid_Out pulses starting 6 cycles after the first input, Data_Out = 0x3F800000 .. 0x41000000 (1.0..8.0).
- NUM_CH=2, all ones, Bias=0x3F000000 (0.5): two consecutive Valid_In -> exactly one Valid_Out, 6 cycles after the second input, Data_Out=0x41940000 (18.5); Ch_Idx sequence 0,1,0.
- Stall: assert Stall for 3 cycles starting 2 cycles after Valid_In -> Valid_Out arrives 3 cycles late, same value; Valid_In pulses during the stall produce no output.
- Clear/reset: NUM_CH=2, one channel in, then Clear -> the next two channels yield 18.5, not a mixed sum. Drop rst mid-tree -> no Valid_Out, Data_Out=0.
- Kernels = 0xBF800000 (-1.0), all Data 1.0, Bias=0: without CONVO_KXK_RELU_EN Data_Out=0xC1100000 (-9.0); with it Data_Out=0x00000000.
